// File: rtl/if_id_skid.sv
// IF/ID pipeline stage with a 2-entry skid buffer, so if_ready comes straight from a flop.
// Optional stall/bubble performance counters are enabled by defining IF_ID_PERF_CNT_EN.
module if_id_skid #(
  parameter int ADDR_W     = 32,
  parameter int INST_W     = 32,
  parameter int SIDE_W     = 2,
  parameter bit FLUSH_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic [INST_W-1:0] if_inst,
  input  logic [SIDE_W-1:0] if_side,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic [SIDE_W-1:0] id_side
`ifdef IF_ID_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt
`endif
);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
    logic [SIDE_W-1:0] side;
  } beat_t;

  beat_t main_q, main_d, skid_q, skid_d, in_beat;
  logic  main_v_q, main_v_d, skid_v_q, skid_v_d;
  logic  if_ready_q, if_ready_d;
  logic  in_fire, out_fire, main_free;

  assign in_beat   = '{pc: if_pc, inst: if_inst, side: if_side};
  assign in_fire   = if_valid & if_ready_q;
  assign out_fire  = main_v_q & id_ready;
  assign main_free = ~main_v_q | out_fire;

  always_comb begin
    main_d   = main_q;
    skid_d   = skid_q;
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    if (flush) begin
      // Flush wins over everything; an incoming beat this cycle is dropped.
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
      if (FLUSH_ZERO) begin
        main_d = '0;
        skid_d = '0;
      end
    end else if (main_free) begin
      if (skid_v_q) begin
        main_d   = skid_q;
        main_v_d = 1'b1;
        skid_v_d = 1'b0;
      end else begin
        main_v_d = in_fire;
        if (in_fire) main_d = in_beat;
      end
    end else if (in_fire) begin
      skid_d   = in_beat;
      skid_v_d = 1'b1;
    end
    // Ready is the inverse of the next skid state, so decode never reaches fetch combinationally.
    if_ready_d = ~skid_v_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_v_q   <= 1'b0;
      skid_v_q   <= 1'b0;
      if_ready_q <= 1'b1;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_v_q   <= main_v_d;
      skid_v_q   <= skid_v_d;
      if_ready_q <= if_ready_d;
    end
  end

  assign if_ready = if_ready_q;
  assign id_valid = main_v_q;
  assign id_pc    = main_q.pc;
  assign id_inst  = main_q.inst;
  assign id_side  = main_q.side;

`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, bubble_cnt_q, bubble_cnt_d;

  // Free-running and wrapping; flush deliberately leaves these alone.
  always_comb begin
    stall_cnt_d  = stall_cnt_q + {31'd0, main_v_q & ~id_ready};
    bubble_cnt_d = bubble_cnt_q + {31'd0, ~main_v_q & id_ready};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_skid.sv
// Directed bench for if_id_skid: a queue-based model of the stage checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_if_id_skid;
  localparam int ADDR_W = 32, INST_W = 32, SIDE_W = 2;

  logic              clk = 1'b0;
  logic              rst, flush, if_valid, id_ready;
  logic              if_ready, id_valid;
  logic [ADDR_W-1:0] if_pc, id_pc;
  logic [INST_W-1:0] if_inst, id_inst;
  logic [SIDE_W-1:0] if_side, id_side;
`ifdef IF_ID_PERF_CNT_EN
  logic [31:0]       stall_cnt, bubble_cnt;
`endif

  int errors = 0;
  int checks = 0;

  if_id_skid #(.ADDR_W(ADDR_W), .INST_W(INST_W), .SIDE_W(SIDE_W), .FLUSH_ZERO(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_inst(if_inst), .if_side(if_side),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_inst(id_inst), .id_side(id_side)
`ifdef IF_ID_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
    logic [SIDE_W-1:0] side;
  } beat_t;

  // Model: the stage is a FIFO of depth 2 that flush and reset empty.
  beat_t q[$];

  always @(posedge clk or negedge rst) begin
    if (!rst) q.delete();
    else begin
      automatic bit of  = (q.size() > 0) && id_ready;
      automatic bit inf = if_valid && (q.size() < 2);
      if (flush) q.delete();
      else begin
        if (of) void'(q.pop_front());
        if (inf) q.push_back('{pc: if_pc, inst: if_inst, side: if_side});
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      chk("model id_valid", 64'(id_valid), 64'(q.size() > 0));
      chk("model if_ready", 64'(if_ready), 64'(q.size() < 2));
      if (q.size() > 0) begin
        chk("model id_pc", 64'(id_pc), 64'(q[0].pc));
        chk("model id_inst", 64'(id_inst), 64'(q[0].inst));
        chk("model id_side", 64'(id_side), 64'(q[0].side));
      end
      if (id_valid && id_pc == 32'h300) chk("flushed beat leaked", 64'(id_pc), 64'h0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc);
    if_valid = v;
    if_pc    = pc;
    if_inst  = pc ^ 32'hA5A5_0000;
    if_side  = pc[3:2];
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; id_ready = 1'b0;
    if_valid = 1'($urandom); if_pc = $urandom; if_inst = $urandom; if_side = 2'($urandom);
    #12;
    chk("reset id_valid", 64'(id_valid), 64'd0);
    chk("reset if_ready", 64'(if_ready), 64'd1);
    chk("reset id_pc", 64'(id_pc), 64'd0);
    chk("reset id_inst", 64'(id_inst), 64'd0);
    chk("reset id_side", 64'(id_side), 64'd0);
    tick();
    rst = 1'b1;
    if_valid = 1'b1; if_pc = 32'h100; if_inst = 32'h2401_0005; if_side = 2'd1;
    tick();
    chk("first id_valid", 64'(id_valid), 64'd1);
    chk("first id_pc", 64'(id_pc), 64'h100);
    chk("first id_inst", 64'(id_inst), 64'h2401_0005);
    if_valid = 1'b0; id_ready = 1'b1;
    tick();

    // Streaming: 8 back-to-back beats at full rate.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'(4 * i));
      tick();
      chk("stream id_valid", 64'(id_valid), 64'd1);
      chk("stream id_pc", 64'(id_pc), 64'(4 * i));
      chk("stream if_ready", 64'(if_ready), 64'd1);
    end
    drive(1'b0, 32'h0);
    tick();
    chk("stream drained", 64'(id_valid), 64'd0);

    // Stall and skid.
    id_ready = 1'b0;
    drive(1'b1, 32'h200);
    tick();
    chk("stall pc0", 64'(id_pc), 64'h200);
    chk("stall ready0", 64'(if_ready), 64'd1);
    drive(1'b1, 32'h204);
    tick();
    chk("stall full", 64'(if_ready), 64'd0);
    chk("stall pc1", 64'(id_pc), 64'h200);
    drive(1'b1, 32'h208);
    tick();
    tick();
    chk("stall held pc", 64'(id_pc), 64'h200);
    chk("stall held ready", 64'(if_ready), 64'd0);
    id_ready = 1'b1;
    tick();
    chk("drain pc1", 64'(id_pc), 64'h204);
    chk("drain ready", 64'(if_ready), 64'd1);
    tick();
    chk("drain pc2", 64'(id_pc), 64'h208);
    drive(1'b0, 32'h0);
    tick();
    chk("drain empty", 64'(id_valid), 64'd0);

    // Flush with two beats held and a beat on the input.
    id_ready = 1'b0;
    drive(1'b1, 32'h280); tick();
    drive(1'b1, 32'h284); tick();
    chk("pre-flush full", 64'(if_ready), 64'd0);
    drive(1'b1, 32'h300); flush = 1'b1;
    tick();
    flush = 1'b0; drive(1'b0, 32'h0);
    chk("flush id_valid", 64'(id_valid), 64'd0);
    chk("flush if_ready", 64'(if_ready), 64'd1);
    chk("flush id_pc zero", 64'(id_pc), 64'd0);
    tick();
    chk("flush stays empty", 64'(id_valid), 64'd0);

    // Flush while decode is consuming.
    id_ready = 1'b1;
    drive(1'b1, 32'h400); tick();
    chk("oflush pre", 64'(id_pc), 64'h400);
    drive(1'b1, 32'h404); flush = 1'b1;
    tick();
    flush = 1'b0; drive(1'b0, 32'h0);
    chk("oflush id_valid", 64'(id_valid), 64'd0);
    tick();
    chk("oflush no more", 64'(id_valid), 64'd0);

    // Reset asserted mid-stall, between edges.
    id_ready = 1'b0;
    drive(1'b1, 32'h500); tick();
    drive(1'b1, 32'h504); tick();
    chk("prerst full", 64'(if_ready), 64'd0);
    #2 rst = 1'b0;
    #1;
    chk("arst id_valid", 64'(id_valid), 64'd0);
    chk("arst if_ready", 64'(if_ready), 64'd1);
    chk("arst id_pc", 64'(id_pc), 64'd0);
    drive(1'b0, 32'h0);
    tick();
    rst = 1'b1;
    tick();

`ifdef IF_ID_PERF_CNT_EN
    rst = 1'b0; id_ready = 1'b0; #1; rst = 1'b1;
    drive(1'b1, 32'h600); tick();
    drive(1'b0, 32'h0);
    repeat (5) tick();
    id_ready = 1'b1;
    tick();
    repeat (3) tick();
    id_ready = 1'b0;
    #1;
    chk("stall_cnt", 64'(stall_cnt), 64'd5);
    chk("bubble_cnt", 64'(bubble_cnt), 64'd3);
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
